// File: rtl/spi_frame_capture.sv
`timescale 1ns/1ps
// Passive SPI (mode 0, MSB first) frame capture: 24-bit CS frames split into two words, FIFO-buffered.
// Latency: CS rise at first sync flop edge k -> frame in FIFO after edge k+SYNC_STAGES+1.
// Backpressure: frame_valid_o/frame_ready_i; full FIFO drops the new frame and pulses overflow_o.
// Optional SPI_CAPTURE_STATS_EN adds saturating frame_cnt_o / err_cnt_o counters.

module spi_frame_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             head_vld,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it
   assign rd_en    = pop & head_vld;
   assign wr_en    = push & (~full | rd_en);
   assign head_vld = (wr_ptr != rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_dat = mem[rd_ptr[AW-1:0]];

   // Storage and pointers; storage is cleared so the head reads zero out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
endmodule

module spi_frame_capture #(
   parameter int DATA_W      = 12,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sclk_i,
   input  logic              spi_cs_n_i,
   input  logic              spi_mosi_i,
   output logic              frame_valid_o,
   input  logic              frame_ready_i,
   output logic [DATA_W-1:0] data0_o,
   output logic [DATA_W-1:0] data1_o,
   output logic              frame_err_o,
   output logic              overflow_o,
   output logic              busy_o
`ifdef SPI_CAPTURE_STATS_EN
   ,
   output logic [15:0]       frame_cnt_o,
   output logic [15:0]       err_cnt_o
`endif
);
   localparam int FRAME_W = 2 * DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

   typedef enum logic [2:0] {WAIT_IDLE, IDLE, SHIFT, FULL, OVERRUN} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_hist;
   logic                   cs_hist;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;
   logic                   sclk_rise;
   logic                   cs_rise;

   state_t                 state;
   logic [FRAME_W-1:0]     shreg;
   logic [FRAME_W-1:0]     shift_next;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_next;
   logic                   push_req;
   logic [FRAME_W-1:0]     push_dat;
   logic [FRAME_W-1:0]     head_dat;
   logic                   fifo_full;
   logic                   pop;
   logic                   accept;

   assign sclk_s     = sclk_sync[SYNC_STAGES-1];
   assign cs_s       = cs_sync[SYNC_STAGES-1];
   assign mosi_s     = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise  = sclk_s & ~sclk_hist;
   assign cs_rise    = cs_s & ~cs_hist;
   assign shift_next = {shreg[FRAME_W-2:0], mosi_s};
   assign cnt_next   = cnt + CNT_W'(1);
   assign pop        = frame_valid_o & frame_ready_i;
   assign accept     = push_req & (~fifo_full | pop);

   // Synchronizers plus edge-history flops; cs resets low so a frame live at reset release is waited out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '0;
         mosi_sync <= '0;
         sclk_hist <= 1'b0;
         cs_hist   <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         sclk_hist <= sclk_s;
         cs_hist   <= cs_s;
      end
   end

   // Frame FSM; an SCLK rise coincident with CS rise is shifted in before the CS rise is judged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WAIT_IDLE;
         shreg       <= '0;
         cnt         <= '0;
         push_req    <= 1'b0;
         push_dat    <= '0;
         frame_err_o <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         push_req    <= 1'b0;
         frame_err_o <= 1'b0;
         case (state)
            WAIT_IDLE: if (cs_s) state <= IDLE;
            IDLE: if (!cs_s) begin
               shreg  <= '0;
               cnt    <= '0;
               state  <= SHIFT;
               busy_o <= 1'b1;
            end
            SHIFT: begin
               if (sclk_rise) begin
                  shreg <= shift_next;
                  cnt   <= cnt_next;
                  if (cnt_next == FRAME_CNT) begin
                     busy_o <= 1'b0;
                     if (cs_rise) begin
                        push_req <= 1'b1;
                        push_dat <= shift_next;
                        state    <= IDLE;
                     end else begin
                        state <= FULL;
                     end
                  end else if (cs_rise) begin
                     frame_err_o <= 1'b1;
                     busy_o      <= 1'b0;
                     state       <= IDLE;
                  end
               end else if (cs_rise) begin
                  frame_err_o <= 1'b1;
                  busy_o      <= 1'b0;
                  state       <= IDLE;
               end
            end
            FULL: begin
               if (sclk_rise) begin
                  if (cs_rise) begin
                     frame_err_o <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     busy_o <= 1'b1;
                     state  <= OVERRUN;
                  end
               end else if (cs_rise) begin
                  push_req <= 1'b1;
                  push_dat <= shreg;
                  state    <= IDLE;
               end
            end
            OVERRUN: if (cs_rise) begin
               frame_err_o <= 1'b1;
               busy_o      <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               busy_o <= 1'b0;
               state  <= WAIT_IDLE;
            end
         endcase
      end
   end

   // Overflow flags a completed frame that found no room in the FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overflow_o <= 1'b0;
      else        overflow_o <= push_req & ~accept;
   end

   spi_frame_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push_req),
      .push_dat (push_dat),
      .pop      (pop),
      .head_dat (head_dat),
      .head_vld (frame_valid_o),
      .full     (fifo_full)
   );

   assign data0_o = head_dat[FRAME_W-1:DATA_W];
   assign data1_o = head_dat[DATA_W-1:0];

`ifdef SPI_CAPTURE_STATS_EN
   logic [1:0] err_inc;
   assign err_inc = {1'b0, frame_err_o} + {1'b0, overflow_o};

   // Saturating counters of accepted frames and of error/overflow pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_o <= '0;
         err_cnt_o   <= '0;
      end else begin
         if (accept && frame_cnt_o != 16'hFFFF) frame_cnt_o <= frame_cnt_o + 16'd1;
         if ({1'b0, err_cnt_o} + {15'd0, err_inc} > 17'h0FFFF) err_cnt_o <= 16'hFFFF;
         else                                                err_cnt_o <= err_cnt_o + {14'd0, err_inc};
      end
   end
`else
   // Statistics counters are not built in this configuration
`endif
endmodule
